apx_pipe_adder_array: RTL and testbench
=======================================

// Module: apx_pipe_adder_array
// PURPOSE
//  Multi-lane, 2-stage pipelined HOAANED-style approximate adder with a runtime-selectable imprecise width.
//  Successor to the fixed combinational approximate adder: width, lane count and approximation depth are all generalised.
//  Sits between the PE partial-product reducers and the accumulator/output buffer of the systolic array.
//  Uses a valid/ready stream on both sides, so array back-pressure stalls it cleanly.
// PARAMETERS
//  ADDER_LENGTH  32  operand width in bits; sum is ADDER_LENGTH+1 bits
//  LANES         4   independent adder channels sharing one handshake
//  MAX_IMPRECISE 16  largest legal imprecise width k; must be >=2 and <=ADDER_LENGTH/2
//  SEL_W         5   width of imp_sel; must satisfy 2**SEL_W > MAX_IMPRECISE
// PORTS
//  clk        in   1                        clock; all state updates on rising edge
//  rst_n      in   1                        asynchronous active-low reset
//  in_valid   in   1                        input beat valid
//  in_ready   out  1                        block can accept a beat
//  imp_sel    in   SEL_W                    imprecise width k for this beat; sampled with the data
//  a          in   LANES*ADDER_LENGTH       lane i operand = a[i*ADDER_LENGTH +: ADDER_LENGTH]
//  b          in   LANES*ADDER_LENGTH       lane i operand, same packing as a
//  out_valid  out  1                        result beat valid
//  out_ready  in   1                        downstream accepts the result
//  sum        out  LANES*(ADDER_LENGTH+1)   per-lane sums, packed like a
//  out_imp    out  SEL_W                    k that was used for this result beat
// BEHAVIOUR
//  Approximation rule, per lane, with k = effective imp_sel:
//   - k==0 or k==1: exact addition.
//   - 2<=k<=MAX_IMPRECISE:
//     - sum[k-3:0] = all 1s.
//     - sum[k-2] = a|b.
//     - g = a[k-1]&b[k-1]; p2 = a[k-2]&b[k-2].
//     - sum[k-1] = g ? p2 : (a[k-1]|b[k-1]|p2).
//     - Carry into bit k = g; bits [ADDER_LENGTH-1:k] are an exact ripple add.
//     - sum[ADDER_LENGTH] = final carry out.
//  imp_sel>MAX_IMPRECISE is clamped to MAX_IMPRECISE; out_imp reports the clamped value.
//  Pipeline stage S1 (registered):
//   - low ADDER_LENGTH/2 result bits.
//   - carry out of the low half.
//   - upper operand halves.
//   - k.
//  Pipeline stage S2 (registered):
//   - upper half + S1 carry.
//   - concatenated final sum.
//  Latency: exactly 2 cycles from the accepting edge to out_valid with no stall.
//  Throughput: 1 beat/cycle.
//  Handshake:
//   - A beat transfers on an edge where valid&ready are both high.
//   - in_ready = !s1_v | (!s2_v | out_ready)   (S1 may load when S1 is empty or S1 moves to S2).
//   - S2 loads when !s2_v | out_ready.
//   - out_valid = s2_v.
//   - While out_valid & !out_ready: sum and out_imp are held stable and nothing is lost or duplicated.
//   - Simultaneous output pop and input push when full: both occur; occupancy stays at 2.
//  Reset (asynchronous assert, synchronous deassert handled by the top level):
//   - s1_v, s2_v, out_valid = 0; sum = 0; out_imp = 0; in_ready = 1 on the first cycle after release.
//   - Reset mid-operation drops in-flight beats silently.
//  No combinational path from in_valid to out_valid.
//  The out_ready->in_ready path is combinational and intentional.
// CONFIGURATION
//  APX_ERR_MON_EN defined:
//   - An exact sum is pipelined alongside each lane.
//   - Extra outputs: err_abs [LANES*(ADDER_LENGTH+1)] = |exact - approx|, valid with out_valid.
//   - Extra output: err_cnt [32], a saturating count of transferred lanes with a nonzero error.
//   - Extra input: err_clr, a synchronous clear of err_cnt; clear wins over an increment in the same cycle.
//   - Reset value of both new outputs = 0.
//  APX_ERR_MON_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package apx_pkg: SEL_W, the MAX_IMPRECISE legality check function, clamp function, lane pack/unpack macros.
//  Sub-module apx_lane_half: combinational approximate/exact half-adder slice (a, b, cin, k, low/high mode -> s, cout).
//   - Instantiated 2*LANES times.
//  Top module: generate-loop over lanes, the pipeline valid/data registers and handshake logic.
// TESTING
//  ADDER_LENGTH=8, k=0, a=0xFF, b=0x01 -> sum=0x100 after 2 cycles.
//  k=4, a=0x0F, b=0x01 -> sum=0x00F; with APX_ERR_MON_EN, err_abs=1.
//  k=4, a=0x88, b=0x88 -> sum=0x113, err_abs=3.
//  imp_sel=31 -> treated as MAX_IMPRECISE; out_imp equals MAX_IMPRECISE.
//  Continuous stream of 10 beats with out_ready low for cycles 3-6 -> no loss or duplication, order preserved, in_ready low while full.
//  rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/apx_pkg.sv
// Shared definitions for the pipelined approximate adder array: selector width,
// configuration legality and clamp helpers, and the lane pack/unpack macro.
`ifndef APX_PKG_SV
`define APX_PKG_SV

// Lane i of a packed multi-lane vector whose lanes are w bits wide.
`define APX_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package apx_pkg;

  localparam int SEL_W = 5;

  // Slice role: the low half applies the approximation, the high half is exact.
  typedef enum logic {
    HALF_LOW  = 1'b0,
    HALF_HIGH = 1'b1
  } half_mode_e;

  // The approximate region must fit in the low half, so the pipeline split
  // never cuts through it, and the selector must be able to encode the maximum.
  function automatic bit apx_cfg_legal(input int adder_length,
                                       input int max_imp,
                                       input int sel_w);
    return (max_imp >= 2) && (max_imp <= adder_length / 2) &&
           ((1 << sel_w) > max_imp);
  endfunction

  function automatic int apx_clamp(input int sel, input int max_imp);
    return (sel > max_imp) ? max_imp : sel;
  endfunction

endpackage

`endif

// File: rtl/apx_lane_half.sv
// Combinational half-width adder slice. In HALF_LOW mode it applies the
// HOAANED-style approximation over the bottom k bits; in HALF_HIGH mode it is exact.
module apx_lane_half
  import apx_pkg::*;
#(
  parameter int W     = 16,
  parameter int SEL_W = apx_pkg::SEL_W
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  input  logic [SEL_W-1:0] k,
  input  half_mode_e       mode,
  output logic [W-1:0]     s,
  output logic             cout
);

  int k_eff;

  assign k_eff = (mode == HALF_HIGH) ? 0 : int'(k);

  always_comb begin
    logic carry;
    logic g;
    logic p_prev;
    // NOTE: every variable gets a value before any branch so no path leaves one
    // unassigned; a missing default here would infer a latch.
    s      = '0;
    carry  = cin;
    g      = 1'b0;
    p_prev = 1'b0;
    // NOTE: blocking assignments are intentional: carry and p_prev must ripple
    // from bit to bit within one evaluation of this block.
    for (int i = 0; i < W; i++) begin
      if (k_eff >= 2 && i < k_eff - 2) begin
        s[i] = 1'b1;
      end else if (k_eff >= 2 && i == k_eff - 2) begin
        s[i] = a[i] | b[i];
      end else if (k_eff >= 2 && i == k_eff - 1) begin
        // Top imprecise bit: generate here becomes the carry into the exact part.
        g     = a[i] & b[i];
        s[i]  = g ? p_prev : (a[i] | b[i] | p_prev);
        carry = g;
      end else begin
        s[i]  = a[i] ^ b[i] ^ carry;
        carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      p_prev = a[i] & b[i];
    end
    cout = carry;
  end

endmodule

// File: rtl/apx_pipe_adder_array.sv
// Multi-lane two-stage pipelined approximate adder with a valid/ready stream on
// both sides. Optional error monitor enabled by defining APX_ERR_MON_EN.
module apx_pipe_adder_array
  import apx_pkg::*;
#(
  parameter int ADDER_LENGTH  = 32,
  parameter int LANES         = 4,
  parameter int MAX_IMPRECISE = 16,
  parameter int SEL_W         = apx_pkg::SEL_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SEL_W-1:0]                  imp_sel,
  input  logic [LANES*ADDER_LENGTH-1:0]     a,
  input  logic [LANES*ADDER_LENGTH-1:0]     b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*(ADDER_LENGTH+1)-1:0] sum,
  output logic [SEL_W-1:0]                  out_imp
`ifdef APX_ERR_MON_EN
  ,
  input  logic                              err_clr,
  output logic [LANES*(ADDER_LENGTH+1)-1:0] err_abs,
  output logic [31:0]                       err_cnt
`endif
);

  localparam int LO_W  = ADDER_LENGTH / 2;
  localparam int HI_W  = ADDER_LENGTH - LO_W;
  localparam int SUM_W = ADDER_LENGTH + 1;

  if (!apx_cfg_legal(ADDER_LENGTH, MAX_IMPRECISE, SEL_W)) begin : g_cfg_check
    $error("apx_pipe_adder_array: MAX_IMPRECISE/SEL_W out of legal range");
  end

  // Everything the upper half still needs once the low half is resolved.
  typedef struct packed {
    logic [HI_W-1:0] a_hi;
    logic [HI_W-1:0] b_hi;
    logic [LO_W-1:0] lo;
    logic            carry;
  } s1_lane_t;

  logic [SEL_W-1:0] k_in;
  logic             s1_v;
  logic             s2_v;
  logic             s2_load;
  logic [SEL_W-1:0] s1_k;
  logic [SEL_W-1:0] s2_k;
  s1_lane_t         s1_d   [LANES];
  s1_lane_t         s1_q   [LANES];
  logic [SUM_W-1:0] sum_d  [LANES];
  logic [SUM_W-1:0] s2_sum [LANES];

  assign k_in = SEL_W'(apx_clamp(int'(imp_sel), MAX_IMPRECISE));

  // out_ready reaches in_ready combinationally so a full pipe can pop and push
  // on the same edge.
  assign s2_load   = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_load;
  assign out_valid = s2_v;
  assign out_imp   = s2_k;

`ifdef APX_ERR_MON_EN
  logic [SUM_W-1:0] s1_exact [LANES];
  logic [SUM_W-1:0] exact_d  [LANES];
  logic [SUM_W-1:0] err_d    [LANES];
  logic [SUM_W-1:0] s2_err   [LANES];
  logic [31:0]      nz_cnt;
  logic [32:0]      cnt_sum;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ADDER_LENGTH-1:0] a_l;
    logic [ADDER_LENGTH-1:0] b_l;
    logic [LO_W-1:0]         lo_s;
    logic                    lo_c;
    logic [HI_W-1:0]         hi_s;
    logic                    hi_c;

    assign a_l = `APX_LANE(a, l, ADDER_LENGTH);
    assign b_l = `APX_LANE(b, l, ADDER_LENGTH);

    apx_lane_half #(
      .W     (LO_W),
      .SEL_W (SEL_W)
    ) u_lo (
      .a    (a_l[LO_W-1:0]),
      .b    (b_l[LO_W-1:0]),
      .cin  (1'b0),
      .k    (k_in),
      .mode (HALF_LOW),
      .s    (lo_s),
      .cout (lo_c)
    );

    assign s1_d[l] = {a_l[ADDER_LENGTH-1:LO_W], b_l[ADDER_LENGTH-1:LO_W], lo_s, lo_c};

    apx_lane_half #(
      .W     (HI_W),
      .SEL_W (SEL_W)
    ) u_hi (
      .a    (s1_q[l].a_hi),
      .b    (s1_q[l].b_hi),
      .cin  (s1_q[l].carry),
      .k    (s1_k),
      .mode (HALF_HIGH),
      .s    (hi_s),
      .cout (hi_c)
    );

    assign sum_d[l] = {hi_c, hi_s, s1_q[l].lo};
    assign `APX_LANE(sum, l, SUM_W) = s2_sum[l];

`ifdef APX_ERR_MON_EN
    assign exact_d[l] = {1'b0, a_l} + {1'b0, b_l};
    assign err_d[l]   = (s1_exact[l] >= sum_d[l]) ? (s1_exact[l] - sum_d[l])
                                                  : (sum_d[l] - s1_exact[l]);
    assign `APX_LANE(err_abs, l, SUM_W) = s2_err[l];
`endif
  end

  // Stage 1: low-half result, its carry, the raw upper halves and k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, not just the valids, because the
      // outputs they drive must read zero straight out of reset.
      s1_v <= 1'b0;
      s1_k <= '0;
      for (int i = 0; i < LANES; i++) s1_q[i] <= '0;
    end else if (in_ready) begin
      // NOTE: non-blocking assignments for all state so every register samples
      // pre-edge values regardless of statement order.
      s1_v <= in_valid;
      if (in_valid) begin
        s1_k <= k_in;
        for (int i = 0; i < LANES; i++) s1_q[i] <= s1_d[i];
      end
    end
  end

  // Stage 2: upper half plus carry, concatenated into the final sum; held
  // while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_k <= '0;
      for (int i = 0; i < LANES; i++) s2_sum[i] <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_k <= s1_k;
        for (int i = 0; i < LANES; i++) s2_sum[i] <= sum_d[i];
      end
    end
  end

`ifdef APX_ERR_MON_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        s1_exact[i] <= '0;
        s2_err[i]   <= '0;
      end
    end else begin
      if (in_ready && in_valid) begin
        for (int i = 0; i < LANES; i++) s1_exact[i] <= exact_d[i];
      end
      if (s2_load && s1_v) begin
        for (int i = 0; i < LANES; i++) s2_err[i] <= err_d[i];
      end
    end
  end

  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < LANES; i++) nz_cnt = nz_cnt + 32'(|s2_err[i]);
    cnt_sum = {1'b0, err_cnt} + {1'b0, nz_cnt};
  end

  // Counts lanes with nonzero error on transferred beats; saturates, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (s2_v && out_ready) begin
      err_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_apx_pipe_adder_array.sv
// Self-checking bench for apx_pipe_adder_array: directed corner cases plus
// randomized traffic against an arithmetic reference model and a beat queue.
`timescale 1ns/1ps
module tb_apx_pipe_adder_array;

  localparam int L    = 8;
  localparam int N    = 4;
  localparam int MAXK = 4;
  localparam int SELW = 5;
  localparam int SUMW = L + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [SELW-1:0]   imp_sel;
  logic [N*L-1:0]    a;
  logic [N*L-1:0]    b;
  logic              out_valid;
  logic              out_ready;
  logic [N*SUMW-1:0] sum;
  logic [SELW-1:0]   out_imp;
`ifdef APX_ERR_MON_EN
  logic              err_clr;
  logic [N*SUMW-1:0] err_abs;
  logic [31:0]       err_cnt;
`endif

  apx_pipe_adder_array #(
    .ADDER_LENGTH  (L),
    .LANES         (N),
    .MAX_IMPRECISE (MAXK),
    .SEL_W         (SELW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imp_sel   (imp_sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .out_imp   (out_imp)
`ifdef APX_ERR_MON_EN
    ,
    .err_clr   (err_clr),
    .err_abs   (err_abs),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*SUMW-1:0] sum;
    logic [SELW-1:0]   k;
    logic [N*SUMW-1:0] err;
    int                nz;
  } exp_t;

  exp_t q[$];
  int   n_checks      = 0;
  int   n_miscompares = 0;
  int   n_acc         = 0;
  int   n_pop         = 0;
  bit   mon_en        = 1'b0;
  bit   saw_full_stall = 1'b0;
  int   model_cnt     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Approximation rule written as plain integer arithmetic on one lane.
  function automatic logic [SUMW-1:0] ref_sum(input int unsigned av, input int unsigned bv, input int k);
    int unsigned orv, g, p2, top, lo, hi;
    if (k < 2) return SUMW'(av + bv);
    orv = av | bv;
    g   = (av >> (k - 1)) & (bv >> (k - 1)) & 1;
    p2  = (av >> (k - 2)) & (bv >> (k - 2)) & 1;
    top = (g != 0) ? p2 : (((orv >> (k - 1)) & 1) | p2);
    lo  = ((1 << (k - 2)) - 1) | (((orv >> (k - 2)) & 1) << (k - 2)) | (top << (k - 1));
    hi  = (av >> k) + (bv >> k) + g;
    return SUMW'((hi << k) | lo);
  endfunction

  function automatic exp_t build(input logic [N*L-1:0] av, input logic [N*L-1:0] bv, input logic [SELW-1:0] sel);
    exp_t e;
    int k;
    k = (int'(sel) > MAXK) ? MAXK : int'(sel);
    e.k  = SELW'(k);
    e.nz = 0;
    e.sum = '0;
    e.err = '0;
    for (int l = 0; l < N; l++) begin
      int unsigned x, y, ap, ex;
      int d;
      x  = int'(av[l*L +: L]);
      y  = int'(bv[l*L +: L]);
      ap = int'(ref_sum(x, y, k));
      ex = x + y;
      d  = int'(ap) - int'(ex);
      if (d < 0) d = -d;
      e.sum[l*SUMW +: SUMW] = SUMW'(ap);
      e.err[l*SUMW +: SUMW] = SUMW'(d);
      if (d != 0) e.nz++;
    end
    return e;
  endfunction

  // Scoreboard: sampled on the falling edge, describing the transfers that
  // will happen on the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      if (q.size() == 2 && !out_ready) saw_full_stall = 1'b1;
`ifdef APX_ERR_MON_EN
      check("err_cnt", 64'(err_cnt), 64'(model_cnt));
`endif
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          check("sum", 64'(sum), 64'(q[0].sum));
          check("out_imp", 64'(out_imp), 64'(q[0].k));
`ifdef APX_ERR_MON_EN
          check("err_abs", 64'(err_abs), 64'(q[0].err));
`endif
          if (out_ready) begin
`ifdef APX_ERR_MON_EN
            if (!err_clr) model_cnt += q[0].nz;
`endif
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
`ifdef APX_ERR_MON_EN
      if (err_clr) model_cnt = 0;
`endif
      if (in_valid && in_ready) begin
        q.push_back(build(a, b, imp_sel));
        n_acc++;
      end
    end
  end

  task automatic drain();
    int cyc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic directed(input string tag, input logic [L-1:0] av, input logic [L-1:0] bv,
                          input logic [SELW-1:0] sel, input logic [SUMW-1:0] exp_sum,
                          input logic [SUMW-1:0] exp_err, input logic [SELW-1:0] exp_k);
    logic [31:0] ra, rb;
    ra = $urandom;
    rb = $urandom;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    imp_sel   = sel;
    a = {ra[N*L-1:L], av};
    b = {rb[N*L-1:L], bv};
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check({tag, "_lat2"}, 64'(out_valid), 64'(1));
    check({tag, "_sum"}, 64'(sum[SUMW-1:0]), 64'(exp_sum));
    check({tag, "_imp"}, 64'(out_imp), 64'(exp_k));
`ifdef APX_ERR_MON_EN
    check({tag, "_err"}, 64'(err_abs[SUMW-1:0]), 64'(exp_err));
`else
    if (exp_err > exp_sum + 1) $display("note: %s expects a large error", tag);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, pop0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    imp_sel   = '0;
    a         = '0;
    b         = '0;
`ifdef APX_ERR_MON_EN
    err_clr   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_out_imp", 64'(out_imp), 64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    directed("k0_exact", 8'hFF, 8'h01, 5'd0, 9'h100, 9'h000, 5'd0);
    directed("k4_small", 8'h0F, 8'h01, 5'd4, 9'h00F, 9'h001, 5'd4);
    directed("k4_gen",   8'h88, 8'h88, 5'd4, 9'h113, 9'h003, 5'd4);
    directed("clamp31",  8'h0F, 8'h01, 5'd31, 9'h00F, 9'h001, 5'd4);
    directed("k1_exact", 8'h7F, 8'h01, 5'd1, 9'h080, 9'h000, 5'd1);
    directed("k2_edge",  8'h03, 8'h03, 5'd2, 9'h007, 9'h001, 5'd2);
    drain();

    // Ten-beat stream with the consumer stalled for cycles 3..6.
    acc0 = n_acc;
    pop0 = n_pop;
    saw_full_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (n_acc - acc0) < 10;
      a = $urandom;
      b = $urandom;
      imp_sel = 5'($urandom_range(0, 6));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_accepted", 64'(n_acc - acc0), 64'(10));
    check("stream_popped", 64'(n_pop - pop0), 64'(10));
    check("stream_full_stall", 64'(saw_full_stall), 64'(1));
    drain();

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      a = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      b = $urandom;
      imp_sel = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
`ifdef APX_ERR_MON_EN
      err_clr = ($urandom_range(0, 19) == 0);
`endif
      @(posedge clk); #1;
    end
`ifdef APX_ERR_MON_EN
    err_clr = 1'b0;
`endif
    drain();

    // Reset with two beats in flight: both must vanish.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a = $urandom;
    b = $urandom;
    imp_sel = 5'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_before_rst", 64'(out_valid), 64'(1));
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_sum", 64'(sum), 64'(0));
    q.delete();
    model_cnt = 0;
    @(posedge clk); #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    for (int c = 0; c < 5; c++) begin
      check("post_rst_no_stale", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
